// File: rtl/motor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motor_pkg : shared types, defaults and pin decode for the motor ramp stage   |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
package motor_pkg;

    localparam int DUTY_W_DEF = 13;

    typedef enum logic [1:0] {
        DIR_COAST = 2'b00,
        DIR_FWD   = 2'b01,
        DIR_REV   = 2'b10,
        DIR_BRAKE = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DECEL = 2'd1,
        ST_BRAKE = 2'd2
    } ramp_state_t;

    // Returns {in1, in2} for a bridge direction.
    function automatic logic [1:0] dir_pins(input dir_t d);
        case (d)
            DIR_FWD:   dir_pins = 2'b10;
            DIR_REV:   dir_pins = 2'b01;
            DIR_BRAKE: dir_pins = 2'b11;
            default:   dir_pins = 2'b00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/motor_ramp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motor_ramp_if : command and bridge-drive bundle for motor_ramp             |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
interface motor_ramp_if #(
    parameter int DUTY_W = motor_pkg::DUTY_W_DEF
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DUTY_W-1:0] cmd_duty;
    logic [1:0]        cmd_dir;
    logic              stop;
    logic [DUTY_W-1:0] duty;
    logic              in1;
    logic              in2;
    logic              busy;
    logic              at_target;

    modport master (
        output cmd_valid, cmd_duty, cmd_dir, stop,
        input  cmd_ready, duty, in1, in2, busy, at_target
    );

    modport slave (
        input  cmd_valid, cmd_duty, cmd_dir, stop,
        output cmd_ready, duty, in1, in2, busy, at_target
    );
endinterface
`default_nettype wire

// File: rtl/motor_ramp_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tick_gen : free-running divider, one-cycle tick every DIV clocks            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tick_gen #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);
    localparam int c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == c_LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/motor_ramp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motor_ramp : slew-limited duty/direction stage for one H-bridge channel     |
// | Build macro MOTOR_RAMP_ACTIVE_BRAKE_EN: short-brake pins during reversal    |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module motor_ramp
    import motor_pkg::*;
#(
    parameter int DUTY_W    = DUTY_W_DEF,
    parameter int STEP      = 16,
    parameter int TICK_DIV  = 1000,
    parameter int BRAKE_CYC = 5000
) (
    input  logic          clk,
    input  logic          rst_n,
    motor_ramp_if.slave   bus
);
    localparam logic [DUTY_W:0] c_STEP_X = (DUTY_W + 1)'(STEP);
    localparam int c_BRK_W = (BRAKE_CYC > 1) ? $clog2(BRAKE_CYC) : 1;
    localparam logic [c_BRK_W-1:0] c_BRK_LOAD = c_BRK_W'(BRAKE_CYC - 1);
`ifdef MOTOR_RAMP_ACTIVE_BRAKE_EN
    localparam logic [1:0] c_DEAD_PINS = 2'b11;
`else
    localparam logic [1:0] c_DEAD_PINS = 2'b00;
`endif

    ramp_state_t         state_q, state_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic [DUTY_W-1:0]   target_q, target_d;
    dir_t                cur_dir_q, cur_dir_d;
    dir_t                pend_dir_q, pend_dir_d;
    logic [DUTY_W-1:0]   pend_duty_q, pend_duty_d;
    logic [c_BRK_W-1:0]  brk_q, brk_d;
    logic [1:0]          pins_q, pins_d;

    logic                w_tick;
    logic                w_busy;
    logic                w_accept;
    dir_t                w_cmd_dir;
    logic                w_cmd_idle;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (w_tick)
    );

    // One ramp step toward tgt, evaluated one bit wider so it can neither wrap nor overshoot.
    function automatic logic [DUTY_W-1:0] ramp_step(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W:0] cur_x;
        logic [DUTY_W:0] tgt_x;
        logic [DUTY_W:0] sum_x;
        logic [DUTY_W:0] diff_x;
        cur_x  = {1'b0, cur};
        tgt_x  = {1'b0, tgt};
        sum_x  = cur_x + c_STEP_X;
        diff_x = cur_x - tgt_x;
        ramp_step = cur;
        if (cur_x < tgt_x) begin
            ramp_step = (sum_x > tgt_x) ? tgt : sum_x[DUTY_W-1:0];
        end else if (cur_x > tgt_x) begin
            ramp_step = (diff_x > c_STEP_X) ? (cur - c_STEP_X[DUTY_W-1:0]) : tgt;
        end
    endfunction

    assign w_busy     = (state_q != ST_RUN);
    assign w_accept   = bus.cmd_valid && bus.cmd_ready;
    assign w_cmd_dir  = dir_t'(bus.cmd_dir);
    assign w_cmd_idle = (w_cmd_dir == DIR_COAST) || (w_cmd_dir == DIR_BRAKE);

    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        target_d    = target_q;
        cur_dir_d   = cur_dir_q;
        pend_dir_d  = pend_dir_q;
        pend_duty_d = pend_duty_q;
        brk_d       = brk_q;

        if (bus.stop) begin
            state_d     = ST_RUN;
            duty_d      = '0;
            target_d    = '0;
            cur_dir_d   = DIR_BRAKE;
            pend_dir_d  = DIR_COAST;
            pend_duty_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (w_accept) begin
                        if (w_cmd_idle) begin
                            target_d  = '0;
                            cur_dir_d = w_cmd_dir;
                        end else if ((w_cmd_dir == cur_dir_q) || (cur_dir_q == DIR_COAST) ||
                                     (cur_dir_q == DIR_BRAKE)) begin
                            target_d  = bus.cmd_duty;
                            cur_dir_d = w_cmd_dir;
                        end else begin
                            pend_dir_d  = w_cmd_dir;
                            pend_duty_d = bus.cmd_duty;
                            target_d    = '0;
                            state_d     = ST_DECEL;
                        end
                    end
                    // Ramp toward the freshly accepted target so a command landing on a tick acts at once.
                    if (w_tick) begin
                        duty_d = ramp_step(duty_q, target_d);
                    end
                    if (w_accept && w_cmd_idle) begin
                        duty_d = '0;
                    end
                end
                ST_DECEL: begin
                    if (duty_q == '0) begin
                        state_d = ST_BRAKE;
                        brk_d   = c_BRK_LOAD;
                    end else if (w_tick) begin
                        duty_d = ramp_step(duty_q, target_q);
                    end
                end
                ST_BRAKE: begin
                    if (brk_q == '0) begin
                        state_d   = ST_RUN;
                        cur_dir_d = pend_dir_q;
                        target_d  = pend_duty_q;
                    end else begin
                        brk_d = brk_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end

        pins_d = (state_d == ST_BRAKE) ? c_DEAD_PINS : dir_pins(cur_dir_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            duty_q      <= '0;
            target_q    <= '0;
            cur_dir_q   <= DIR_COAST;
            pend_dir_q  <= DIR_COAST;
            pend_duty_q <= '0;
            brk_q       <= '0;
            pins_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            target_q    <= target_d;
            cur_dir_q   <= cur_dir_d;
            pend_dir_q  <= pend_dir_d;
            pend_duty_q <= pend_duty_d;
            brk_q       <= brk_d;
            pins_q      <= pins_d;
        end
    end

    assign bus.duty      = duty_q;
    assign bus.in1       = pins_q[1];
    assign bus.in2       = pins_q[0];
    assign bus.busy      = w_busy;
    assign bus.cmd_ready = !w_busy && !bus.stop;
    assign bus.at_target = (state_q == ST_RUN) && (duty_q == target_q);

endmodule
`default_nettype wire

// File: tb/tb_motor_ramp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_motor_ramp : scoreboard bench for motor_ramp (TICK_DIV=4, STEP=0x100)    |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_motor_ramp;
    import motor_pkg::*;

    localparam int c_DW   = 13;
    localparam int c_STEP = 256;
    localparam int c_DIV  = 4;
    localparam int c_BRK  = 8;
`ifdef MOTOR_RAMP_ACTIVE_BRAKE_EN
    localparam logic [1:0] c_DEAD = 2'b11;
`else
    localparam logic [1:0] c_DEAD = 2'b00;
`endif
    // Observed tuple is {duty, in1, in2, busy, at_target}.
    localparam logic [16:0] c_RST = 17'h00001;

    typedef struct {
        string       name;
        logic [16:0] val;
        int          gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    motor_ramp_if #(.DUTY_W(c_DW)) bus ();

    motor_ramp #(
        .DUTY_W    (c_DW),
        .STEP      (c_STEP),
        .TICK_DIV  (c_DIV),
        .BRAKE_CYC (c_BRK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic void ev(input string nm, input logic [12:0] d, input logic [1:0] p,
                               input logic b, input logic a, input int g);
        exp_t e;
        e.name = nm;
        e.val  = {d, p, b, a};
        e.gap  = g;
        q.push_back(e);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic monitor_loop();
        logic [16:0] prev;
        logic [16:0] cur;
        int          last;
        exp_t        e;
        prev = c_RST;
        last = 0;
        forever begin
            @(negedge clk);
            cur = {bus.duty, bus.in1, bus.in2, bus.busy, bus.at_target};
            if (!mon_en) begin
                prev = c_RST;
                last = 0;
            end else if (cur !== prev) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got tuple 0x%0h at cycle %0d, want unchanged 0x%0h",
                             cur, cyc, prev);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.val || (e.gap >= 0 && (cyc - last) != e.gap)) begin
                        n_fail++;
                        $display("FAIL %s: got tuple 0x%0h gap %0d, want 0x%0h gap %0d",
                                 e.name, cur, cyc - last, e.val, e.gap);
                    end
                end
                prev = cur;
                last = cyc;
            end
        end
    endtask

    // Next posedge will be one cycle past a tick edge, so commands never coincide with a tick.
    task automatic wait_phase();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cyc % c_DIV == 0) return;
        end
    endtask

    task automatic send_cmd(input string nm, input logic [1:0] dir, input logic [12:0] d);
        wait_phase();
        check({nm, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = dir;
        bus.cmd_duty  = d;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain(input string nm, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (q.size() == 0) return;
            @(negedge clk);
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d events pending, want 0", nm, q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000ns, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = 2'b00;
        bus.cmd_duty  = '0;
        bus.stop      = 1'b0;
        fork
            monitor_loop();
        join_none
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        check("rst_duty",   32'(bus.duty), 32'd0);
        check("rst_pins",   32'({bus.in1, bus.in2}), 32'd0);
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_attgt",  32'(bus.at_target), 32'd1);
        check("rst_ready",  32'(bus.cmd_ready), 32'd1);

        // 1: forward ramp from rest
        ev("t1_pins", 13'h000, 2'b10, 1'b0, 1'b0, -1);
        ev("t1_d100", 13'h100, 2'b10, 1'b0, 1'b0, 3);
        ev("t1_d200", 13'h200, 2'b10, 1'b0, 1'b0, 4);
        ev("t1_d300", 13'h300, 2'b10, 1'b0, 1'b0, 4);
        ev("t1_d400", 13'h400, 2'b10, 1'b0, 1'b1, 4);
        send_cmd("t1", DIR_FWD, 13'h400);
        check("t1_pins_next", 32'({bus.in1, bus.in2}), 32'h2);
        drain("t1", 40);

        // 2: saturated step, then climb to 0x1F80 and clamp at full scale
        ev("t2_acc",  13'h400, 2'b10, 1'b0, 1'b0, -1);
        ev("t2_d450", 13'h450, 2'b10, 1'b0, 1'b1, 3);
        send_cmd("t2a", DIR_FWD, 13'h450);
        drain("t2a", 20);
        ev("t2_acc2", 13'h450, 2'b10, 1'b0, 1'b0, -1);
        for (int k = 1; k <= 27; k++) begin
            ev("t2_climb", 13'(13'h450 + k * c_STEP), 2'b10, 1'b0, 1'b0, (k == 1) ? 3 : 4);
        end
        ev("t2_d1f80", 13'h1F80, 2'b10, 1'b0, 1'b1, 4);
        send_cmd("t2b", DIR_FWD, 13'h1F80);
        drain("t2b", 200);
        ev("t2_acc3",  13'h1F80, 2'b10, 1'b0, 1'b0, -1);
        ev("t2_d1fff", 13'h1FFF, 2'b10, 1'b0, 1'b1, 3);
        send_cmd("t2c", DIR_FWD, 13'h1FFF);
        drain("t2c", 20);

        // 3: reversal from forward 0x200 to reverse 0x300
        ev("t3_coast", 13'h000, 2'b00, 1'b0, 1'b1, -1);
        send_cmd("t3a", DIR_COAST, 13'h0);
        drain("t3a", 10);
        ev("t3_fwd",  13'h000, 2'b10, 1'b0, 1'b0, -1);
        ev("t3_f100", 13'h100, 2'b10, 1'b0, 1'b0, 3);
        ev("t3_f200", 13'h200, 2'b10, 1'b0, 1'b1, 4);
        send_cmd("t3b", DIR_FWD, 13'h200);
        drain("t3b", 20);
        ev("t3_rev",    13'h200, 2'b10,  1'b1, 1'b0, -1);
        ev("t3_dec100", 13'h100, 2'b10,  1'b1, 1'b0, 3);
        ev("t3_dec000", 13'h000, 2'b10,  1'b1, 1'b0, 4);
        ev("t3_dead",   13'h000, c_DEAD, 1'b1, 1'b0, 1);
        ev("t3_runrev", 13'h000, 2'b01,  1'b0, 1'b0, c_BRK);
        ev("t3_r100",   13'h100, 2'b01,  1'b0, 1'b0, 3);
        ev("t3_r200",   13'h200, 2'b01,  1'b0, 1'b0, 4);
        ev("t3_r300",   13'h300, 2'b01,  1'b0, 1'b1, 4);
        send_cmd("t3c", DIR_REV, 13'h300);
        check("t3_ready_busy", 32'(bus.cmd_ready), 32'd0);
        drain("t3c", 60);

        // 4: stop mid-ramp while a command is held
        ev("t4_acc",  13'h300, 2'b01, 1'b0, 1'b0, -1);
        ev("t4_stop", 13'h000, 2'b11, 1'b0, 1'b1, 1);
        send_cmd("t4", DIR_REV, 13'h800);
        @(negedge clk);
        bus.stop      = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = DIR_FWD;
        bus.cmd_duty  = 13'h500;
        #1;
        check("t4_ready_stop", 32'(bus.cmd_ready), 32'd0);
        repeat (5) @(negedge clk);
        check("t4_ready_hold", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        bus.stop = 1'b0;
        drain("t4", 10);

        // 5: coast from forward 0x800 drops duty without ramping
        ev("t5_fwd", 13'h000, 2'b10, 1'b0, 1'b0, -1);
        for (int k = 1; k <= 8; k++) begin
            ev("t5_ramp", 13'(k * c_STEP), 2'b10, 1'b0, (k == 8) ? 1'b1 : 1'b0, (k == 1) ? 3 : 4);
        end
        send_cmd("t5a", DIR_FWD, 13'h800);
        drain("t5a", 60);
        ev("t5_coast", 13'h000, 2'b00, 1'b0, 1'b1, -1);
        send_cmd("t5b", DIR_COAST, 13'h0);
        check("t5_duty_now", 32'(bus.duty), 32'd0);
        check("t5_pins_now", 32'({bus.in1, bus.in2}), 32'd0);
        drain("t5b", 10);

        // 6: async reset in the dead interval clears any pending reversal
        ev("t6_fwd",  13'h000, 2'b10, 1'b0, 1'b0, -1);
        ev("t6_f100", 13'h100, 2'b10, 1'b0, 1'b0, 3);
        ev("t6_f200", 13'h200, 2'b10, 1'b0, 1'b1, 4);
        send_cmd("t6a", DIR_FWD, 13'h200);
        drain("t6a", 20);
        ev("t6_rev",    13'h200, 2'b10,  1'b1, 1'b0, -1);
        ev("t6_dec100", 13'h100, 2'b10,  1'b1, 1'b0, 3);
        ev("t6_dec000", 13'h000, 2'b10,  1'b1, 1'b0, 4);
        ev("t6_dead",   13'h000, c_DEAD, 1'b1, 1'b0, 1);
        send_cmd("t6b", DIR_REV, 13'h100);
        drain("t6b", 20);
        repeat (2) @(negedge clk);
        check("t6_in_brake", 32'(bus.busy), 32'd1);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("t6_rst_duty",  32'(bus.duty), 32'd0);
        check("t6_rst_pins",  32'({bus.in1, bus.in2}), 32'd0);
        check("t6_rst_busy",  32'(bus.busy), 32'd0);
        check("t6_rst_attgt", 32'(bus.at_target), 32'd1);
        check("t6_rst_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        ev("t6_post_fwd", 13'h000, 2'b10, 1'b0, 1'b0, -1);
        ev("t6_post_100", 13'h100, 2'b10, 1'b0, 1'b1, 3);
        send_cmd("t6c", DIR_FWD, 13'h100);
        drain("t6c", 20);
        repeat (24) @(negedge clk);
        check("t6_no_stale_pins", 32'({bus.in1, bus.in2}), 32'h2);
        check("t6_no_stale_duty", 32'(bus.duty), 32'h100);
        drain("final", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
